// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and data
//   load/store (MEM). Contention alternates between the two sources. Each
//   access runs over a variable-latency req/ack memory handshake, and stall_o
//   freezes the pipeline registers while an access is pending or in flight.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_r;
  logic   last_dm_r;
  logic   dm_pend_s;
  logic   grant_if_s;
  logic   grant_dm_s;

  // Grant decision: under contention the source not served last wins
  always_comb begin
    dm_pend_s  = dm_read_i | dm_write_i;
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (dm_pend_s && if_req_i) begin
      grant_if_s = last_dm_r;
      grant_dm_s = ~last_dm_r;
    end else begin
      grant_if_s = if_req_i;
      grant_dm_s = dm_pend_s;
    end
  end

  // Pipeline freeze: high while a request waits for grant or an access is in flight
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      stall_o = 1'b0;
    end else begin
      case (state_r)
        IDLE:             stall_o = dm_pend_s | if_req_i;
        IF_BUSY, DM_BUSY: stall_o = 1'b1;
        DONE:             stall_o = 1'b0;
        default:          stall_o = 1'b0;
      endcase
    end
  end

  // Access sequencer: grant, hold the memory request until ack, pulse completion
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      last_dm_r   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_W{1'b0}};
      mem_wdata_o <= {DATA_W{1'b0}};
      if_data_o   <= {DATA_W{1'b0}};
      dm_rdata_o  <= {DATA_W{1'b0}};
      if_valid_o  <= 1'b0;
      dm_valid_o  <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      dm_valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_dm_s) begin
            // A simultaneous read and write is carried out as a write
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_write_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            last_dm_r   <= 1'b1;
            state_r     <= DM_BUSY;
          end else if (grant_if_s) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= {DATA_W{1'b0}};
            last_dm_r   <= 1'b0;
            state_r     <= IF_BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            if_data_o  <= mem_rdata_i;
            if_valid_o <= 1'b1;
            state_r    <= DONE;
          end else begin
            state_r <= IF_BUSY;
          end
        end
        DM_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            dm_valid_o <= 1'b1;
            state_r    <= DONE;
            // Stores leave the last load result untouched
            if (!mem_we_o) begin
              dm_rdata_o <= mem_rdata_i;
            end else begin
              dm_rdata_o <= dm_rdata_o;
            end
          end else begin
            state_r <= DM_BUSY;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
